// File: rtl/fb_rect_fill.sv
// fb_rect_fill: clips a fill command to the image and streams one pixel write per granted cycle into framebuffer port A
module fb_rect_fill #(
  parameter int IMG_W  = 195,
  parameter int IMG_H  = 146,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [9:0]        i_x0,
  input  logic [9:0]        i_y0,
  input  logic [9:0]        i_w,
  input  logic [9:0]        i_h,
  input  logic [DATA_W-1:0] i_color,
  input  logic              i_fb_grant,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [DATA_W-1:0] o_fb_data,
  output logic              o_busy,
  output logic              o_done
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;
  state_t r_state, w_next;
  logic [9:0] r_x0, r_y0;
  logic [10:0] r_x_end, r_y_end, r_col, r_row;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_color;
  logic [10:0] w_x_sum, w_y_sum;
  logic w_empty, w_accept, w_last_col, w_last_row;
  assign w_accept   = i_cmd_valid & o_cmd_ready;
  assign w_x_sum    = {1'b0, i_x0} + {1'b0, i_w};
  assign w_y_sum    = {1'b0, i_y0} + {1'b0, i_h};
  assign w_empty    = (i_w == 10'd0) | (i_h == 10'd0) | ({1'b0, i_x0} >= 11'(IMG_W)) | ({1'b0, i_y0} >= 11'(IMG_H));
  assign w_last_col = r_col == r_x_end - 11'd1;
  assign w_last_row = r_row == r_y_end - 11'd1;
  assign o_fb_addr  = r_base + ADDR_W'(r_col - {1'b0, r_x0});
  assign o_fb_data  = r_color;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    o_cmd_ready = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    o_fb_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_next = w_empty ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        o_busy = 1'b1;
        w_next = S_FILL;
      end
      S_FILL: begin
        o_busy = 1'b1;
        o_fb_we = i_fb_grant;
        if (i_fb_grant & w_last_col & w_last_row) w_next = S_DONE;
      end
      default: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end
  // row_base tracks the address of column x0 on the current row, so the only multiply is in SETUP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_col <= '0;
      r_row <= '0;
      r_base <= '0;
      r_color <= '0;
    end else if (w_accept) begin
      r_x0 <= i_x0;
      r_y0 <= i_y0;
      r_x_end <= (w_x_sum > 11'(IMG_W)) ? 11'(IMG_W) : w_x_sum;
      r_y_end <= (w_y_sum > 11'(IMG_H)) ? 11'(IMG_H) : w_y_sum;
      r_color <= i_color;
    end else if (r_state == S_SETUP) begin
      r_base <= ADDR_W'(r_y0 * IMG_W + r_x0);
      r_col <= {1'b0, r_x0};
      r_row <= {1'b0, r_y0};
    end else if (o_fb_we) begin
      r_col <= w_last_col ? {1'b0, r_x0} : r_col + 11'd1;
      if (w_last_col) begin
        r_base <= r_base + ADDR_W'(IMG_W);
        r_row <= r_row + 11'd1;
      end
    end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: directed fill commands checked against a pixel-list model of the clipped rectangle
module tb_fb_rect_fill;
  logic clk = 0, rst_n = 1;
  logic i_cmd_valid = 0, i_fb_grant = 0;
  logic [9:0] i_x0 = 0, i_y0 = 0, i_w = 0, i_h = 0;
  logic [15:0] i_color = 0;
  logic o_cmd_ready, o_fb_we, o_busy, o_done;
  logic [14:0] o_fb_addr;
  logic [15:0] o_fb_data;
  int pass = 0, total = 0, cyc = 0;
  int q[$], obs[$], obs_d[$], acc_log[$], done_log[$];
  int m_color;
  bit exp_done = 0, nxt_done, pend = 0, mid = 0;

  fb_rect_fill dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h), .i_color(i_color),
    .i_fb_grant(i_fb_grant), .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
  endtask

  // Model: on acceptance, list every pixel of the clipped rectangle in raster order
  task automatic build(input int x0, input int y0, input int w, input int h);
    int xe, ye;
    xe = (x0 + w > 195) ? 195 : x0 + w;
    ye = (y0 + h > 146) ? 146 : y0 + h;
    q.delete();
    if (w != 0 && h != 0 && x0 < 195 && y0 < 146)
      for (int y = y0; y < ye; y++)
        for (int x = x0; x < xe; x++) q.push_back(y * 195 + x);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      exp_done = 0;
      pend = 0;
      mid = 0;
    end else begin
      chk("done", o_done, exp_done);
      chk("ready", o_cmd_ready, !pend);
      chk("busy", o_busy, pend && !exp_done);
      if (o_done) done_log.push_back(cyc);
      if (exp_done) pend = 0;
      nxt_done = 0;
      if (o_fb_we) begin
        obs.push_back(o_fb_addr);
        obs_d.push_back(o_fb_data);
        if (!i_fb_grant) chk("we_without_grant", 1, 0);
        if (q.size() == 0) chk("spurious_we", 1, 0);
        else begin
          chk("addr", o_fb_addr, q[0]);
          chk("data", o_fb_data, m_color);
          void'(q.pop_front());
          nxt_done = q.size() == 0;
        end
        mid = q.size() != 0;
      end else if (mid) begin
        chk("hold_addr", o_fb_addr, q[0]);
        chk("hold_data", o_fb_data, m_color);
      end
      if (i_cmd_valid && o_cmd_ready) begin
        acc_log.push_back(cyc);
        m_color = i_color;
        build(i_x0, i_y0, i_w, i_h);
        pend = 1;
        if (q.size() == 0) nxt_done = 1;
      end
      exp_done = nxt_done;
    end
  end

  task automatic set_cmd(input int x0, input int y0, input int w, input int h, input int c);
    i_x0 = 10'(x0); i_y0 = 10'(y0); i_w = 10'(w); i_h = 10'(h); i_color = 16'(c);
    i_cmd_valid = 1;
  endtask

  task automatic send(input int x0, input int y0, input int w, input int h, input int c);
    bit ok = 0;
    set_cmd(x0, y0, w, h, c);
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clk);
      ok = o_cmd_ready;
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1 i_cmd_valid = 0;
  endtask

  task automatic wait_done(input int bound, input bit tgl);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = o_done;
      if (tgl && !seen) begin
        @(posedge clk);
        #1 i_fb_grant = !i_fb_grant;
      end
    end
    chk("done_timeout", seen, 1);
  endtask

  task automatic clr();
    obs.delete(); obs_d.delete(); acc_log.delete(); done_log.delete();
  endtask

  initial begin
    int cnt;
    #2 rst_n = 0;
    #1;
    chk("rst_we", o_fb_we, 0);
    chk("rst_addr", o_fb_addr, 0);
    chk("rst_data", o_fb_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    i_fb_grant = 1;
    // T1: 2x2 at origin
    clr();
    send(0, 0, 2, 2, 16'hF800);
    wait_done(50, 0);
    @(posedge clk); #1;
    chk("t1_count", obs.size(), 4);
    chk("t1_a0", obs[0], 0);
    chk("t1_a1", obs[1], 1);
    chk("t1_a2", obs[2], 195);
    chk("t1_a3", obs[3], 196);
    chk("t1_data", obs_d[0], 16'hF800);
    chk("t1_done_lat", done_log[0] - acc_log[0], 6);
    // T2: clipped at bottom-right corner
    clr();
    send(193, 144, 5, 5, 16'h07E0);
    wait_done(50, 0);
    @(posedge clk); #1;
    chk("t2_count", obs.size(), 4);
    chk("t2_a0", obs[0], 28273);
    chk("t2_a1", obs[1], 28274);
    chk("t2_a2", obs[2], 28468);
    chk("t2_a3", obs[3], 28469);
    // T3: empty commands
    clr();
    send(0, 0, 0, 5, 16'h1111);
    wait_done(10, 0);
    @(negedge clk);
    chk("t3_ready_back", o_cmd_ready, 1);
    chk("t3_done_lat", done_log[0] - acc_log[0], 1);
    send(200, 0, 5, 5, 16'h2222);
    wait_done(10, 0);
    @(posedge clk); #1;
    chk("t3_no_writes", obs.size(), 0);
    // T4: toggling grant
    clr();
    i_fb_grant = 0;
    send(10, 3, 3, 1, 16'h1234);
    wait_done(50, 1);
    @(posedge clk); #1;
    chk("t4_count", obs.size(), 3);
    chk("t4_a0", obs[0], 595);
    chk("t4_a1", obs[1], 596);
    chk("t4_a2", obs[2], 597);
    chk("t4_done_lat", done_log[0] - acc_log[0], 7);
    i_fb_grant = 1;
    // T5: reset after the third write
    clr();
    send(0, 0, 10, 10, 16'h5555);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 3; i++) begin
      @(negedge clk);
      if (o_fb_we) cnt++;
    end
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("t5_we_drop", o_fb_we, 0);
    chk("t5_busy_drop", o_busy, 0);
    chk("t5_ready_rst", o_cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t5_ready", o_cmd_ready, 1);
    chk("t5_busy", o_busy, 0);
    chk("t5_writes", obs.size(), 3);
    chk("t5_no_done", done_log.size(), 0);
    // T6: full screen then a back-to-back command held valid
    @(posedge clk); #1;
    clr();
    send(0, 0, 195, 146, 16'hA5A5);
    set_cmd(0, 0, 1, 1, 16'hABCD);
    wait_done(30000, 0);
    @(posedge clk); #1;
    chk("t6_count", obs.size(), 28470);
    chk("t6_last", obs[$], 28469);
    send(0, 0, 1, 1, 16'hABCD);
    wait_done(50, 0);
    @(posedge clk); #1;
    chk("t6_b2b_accept", acc_log[1] - done_log[0], 1);
    chk("t6_second_addr", obs[$], 0);
    chk("t6_second_data", obs_d[$], 16'hABCD);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
